// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: decoder MEM_Ctrl codes, FSM
// state encoding and access-size decode helpers.
package lsu_pkg;

    localparam logic [3:0] MEMC_LD  = 4'b0000;
    localparam logic [3:0] MEMC_LHU = 4'b0001;
    localparam logic [3:0] MEMC_LBU = 4'b0010;
    localparam logic [3:0] MEMC_LW  = 4'b0011;
    localparam logic [3:0] MEMC_LH  = 4'b0100;
    localparam logic [3:0] MEMC_SD  = 4'b1000;
    localparam logic [3:0] MEMC_SW  = 4'b1001;
    localparam logic [3:0] MEMC_SH  = 4'b1010;
    localparam logic [3:0] MEMC_SB  = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} lsu_size_e;

    function automatic lsu_size_e memc_size(input logic [3:0] c);
        case (c)
            MEMC_LD, MEMC_SD:           return SZ_D;
            MEMC_LW, MEMC_SW:           return SZ_W;
            MEMC_LH, MEMC_LHU, MEMC_SH: return SZ_H;
            default:                    return SZ_B;
        endcase
    endfunction

    // Loads occupy 0000..0100, stores 1000..1011; everything else is illegal.
    function automatic logic memc_legal(input logic [3:0] c);
        return (!c[3] && (c[2:0] <= 3'd4)) || (c[3:2] == 2'b10);
    endfunction

    function automatic logic memc_misaligned(input logic [3:0] c, input logic [2:0] off);
        case (memc_size(c))
            SZ_H:    return off[0];
            SZ_W:    return |off[1:0];
            SZ_D:    return |off;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Upstream (decoder/writeback) and downstream (memory bus) bundles of the LSU.
interface lsu_core_if #(parameter int ADDR_W = 64);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        mem_ctrl;
    logic              mem_enable;
    logic [ADDR_W-1:0] addr;
    logic [63:0]       wdata;
    logic              out_valid;
    logic              out_ready;
    logic [63:0]       rdata;
    logic              err_misalign;
    logic              err_illegal;
    logic              err_bus;

    modport master (
        output in_valid, mem_ctrl, mem_enable, addr, wdata, out_ready,
        input  in_ready, out_valid, rdata, err_misalign, err_illegal, err_bus
    );
    modport slave (
        input  in_valid, mem_ctrl, mem_enable, addr, wdata, out_ready,
        output in_ready, out_valid, rdata, err_misalign, err_illegal, err_bus
    );
endinterface

interface lsu_mem_if #(parameter int ADDR_W = 64);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_wen;
    logic [63:0]       req_wdata;
    logic [7:0]        req_wmask;
    logic              resp_valid;
    logic [63:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_addr, req_wen, req_wdata, req_wmask,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_addr, req_wen, req_wdata, req_wmask,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store data/strobe shift and load extract + extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [3:0]  i_ctrl,
    input  logic [2:0]  i_off,
    input  logic [63:0] i_wdata,
    input  logic [63:0] i_rdata,
    output logic [63:0] o_wdata,
    output logic [7:0]  o_wmask,
    output logic [63:0] o_ldata
);
    logic [5:0]  w_sh;
    logic [63:0] w_shr;

    assign w_sh    = {i_off, 3'b000};
    assign o_wdata = i_wdata << w_sh;
    assign w_shr   = i_rdata >> w_sh;

    always_comb begin
        o_wmask = 8'h00;
        if (i_ctrl[3]) begin
            case (memc_size(i_ctrl))
                SZ_B:    o_wmask = 8'h01 << i_off;
                SZ_H:    o_wmask = 8'h03 << i_off;
                SZ_W:    o_wmask = 8'h0F << i_off;
                default: o_wmask = 8'hFF << i_off;
            endcase
        end
    end

    always_comb begin
        o_ldata = '0;
        case (i_ctrl)
            MEMC_LD:  o_ldata = w_shr;
            MEMC_LHU: o_ldata = {48'b0, w_shr[15:0]};
            MEMC_LBU: o_ldata = {56'b0, w_shr[7:0]};
            MEMC_LW:  o_ldata = {{32{w_shr[31]}}, w_shr[31:0]};
            MEMC_LH:  o_ldata = {{48{w_shr[15]}}, w_shr[15:0]};
            default:  o_ldata = '0;
        endcase
    end
endmodule

// File: rtl/lsu_unit.sv
// Multi-cycle load/store unit: one outstanding bus access at a time, with
// misalign/illegal/no-op ops short-circuited straight to the result state.
module lsu_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic        clk,
    input  logic        rst,
    lsu_core_if.slave   core,
    lsu_mem_if.master   mem
);
    lsu_state_e        r_state, w_next;
    logic [3:0]        r_ctrl;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_rdata;
    logic              r_err_mis, r_err_ill, r_err_bus;

    logic              w_accept, w_legal, w_misal, w_skip_bus;
    logic [63:0]       w_st_data, w_ld_data;
    logic [7:0]        w_st_mask;

    assign w_accept   = (r_state == ST_IDLE) && core.in_valid;
    assign w_legal    = memc_legal(core.mem_ctrl);
    assign w_misal    = memc_misaligned(core.mem_ctrl, core.addr[2:0]);
    assign w_skip_bus = !core.mem_enable || !w_legal || w_misal;

    lsu_align u_align (
        .i_ctrl  (r_ctrl),
        .i_off   (r_addr[2:0]),
        .i_wdata (r_wdata),
        .i_rdata (mem.resp_rdata),
        .o_wdata (w_st_data),
        .o_wmask (w_st_mask),
        .o_ldata (w_ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        core.in_ready  = 1'b0;
        core.out_valid = 1'b0;
        mem.req_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                core.in_ready = 1'b1;
                if (core.in_valid) w_next = w_skip_bus ? ST_DONE : ST_REQ;
            end
            ST_REQ: begin
                mem.req_valid = 1'b1;
                if (mem.req_ready) w_next = ST_WAIT;
            end
            ST_WAIT: if (mem.resp_valid) w_next = ST_DONE;
            default: begin
                core.out_valid = 1'b1;
                if (core.out_ready) w_next = ST_IDLE;
            end
        endcase
    end

    // Error flags are resolved at accept time so the DONE outputs are plain registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl    <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_err_mis <= 1'b0;
            r_err_ill <= 1'b0;
            r_err_bus <= 1'b0;
        end else if (w_accept) begin
            r_ctrl    <= core.mem_ctrl;
            r_addr    <= core.addr;
            r_wdata   <= core.wdata;
            r_rdata   <= '0;
            r_err_mis <= core.mem_enable && w_legal && w_misal;
            r_err_ill <= core.mem_enable && !w_legal;
            r_err_bus <= 1'b0;
        end else if (r_state == ST_WAIT && mem.resp_valid) begin
            r_err_bus <= mem.resp_err;
            r_rdata   <= (mem.resp_err || r_ctrl[3]) ? '0 : w_ld_data;
        end
    end

    assign core.rdata        = core.out_valid ? r_rdata : '0;
    assign core.err_misalign = core.out_valid && r_err_mis;
    assign core.err_illegal  = core.out_valid && r_err_ill;
    assign core.err_bus      = core.out_valid && r_err_bus;

    assign mem.req_addr  = {r_addr[ADDR_W-1:3], 3'b000};
    assign mem.req_wen   = r_ctrl[3];
    assign mem.req_wdata = w_st_data;
    assign mem.req_wmask = w_st_mask;
endmodule

// File: doc/lsu_unit.md
Name: lsu_unit

Overview:
- Multi-cycle load/store unit directly downstream of the instruction decoder.
- Consumes the decoder's MEM_Ctrl/MEM_Enable encoding, the ALU-computed address and the rs2 store data.
- Issues one request at a time on a 64-bit valid/ready memory bus, and returns aligned, extended load data to the writeback mux.
- Reports misaligned, illegal-code and bus errors instead of issuing the access.

Parameters:
ADDR_W, 64, width of effective address and bus address
DATA_W, 64, bus data width; fixed at 64 (RV64), other values unsupported

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  upstream has a memory op
in_ready  out  1  unit can accept (state IDLE)
mem_ctrl  in  4  decoder MEM_Ctrl code
mem_enable  in  1  decoder MEM_Enable
addr  in  ADDR_W  effective address
wdata  in  64  store data (rs2)
out_valid  out  1  result available
out_ready  in  1  downstream accepts result
rdata  out  64  extended load data; 0 for stores/errors
err_misalign  out  1  result is a misalignment fault
err_illegal  out  1  result is an unsupported mem_ctrl code
err_bus  out  1  bus returned error
req_valid  out  1  bus request valid
req_ready  in  1  bus accepts request
req_addr  out  ADDR_W  8-byte aligned address {addr[ADDR_W-1:3],3'b0}
req_wen  out  1  1 = store
req_wdata  out  64  lane-shifted store data
req_wmask  out  8  byte strobes; 0 for loads
resp_valid  in  1  bus response valid
resp_rdata  in  64  bus read data
resp_err  in  1  bus error with response

Behaviour:
mem_ctrl codes:
- ld=0000, lhu=0001, lbu=0010, lw=0011, lh=0100
- sd=1000, sw=1001, sh=1010, sb=1011
- 0101, 0110, 0111, 11xx are illegal.

FSM states: IDLE, REQ, WAIT, DONE. Reset puts it in IDLE with all outputs 0 except in_ready=1.

IDLE:
- in_ready=1. On in_valid, latch mem_ctrl, addr, wdata.
- mem_enable=0: go to DONE, all error flags 0, rdata=0, no bus access.
- Illegal code: go to DONE with err_illegal=1.
- Misaligned access: go to DONE with err_misalign=1. Misaligned means halfword with addr[0]≠0, word with addr[1:0]≠0, doubleword with addr[2:0]≠0.
- Otherwise go to REQ.

REQ:
- req_valid=1; req_addr, req_wen, req_wdata and req_wmask held stable until req_ready.
- When req_valid & req_ready, go to WAIT.

WAIT:
- req_valid=0. On resp_valid, capture data and resp_err, then go to DONE.
- resp_valid is never sampled in IDLE or REQ; a stray response is ignored.

DONE:
- out_valid=1 with rdata and error flags stable.
- When out_ready, go to IDLE. in_ready=0 throughout this state.

Lanes (off = addr[2:0]):
- req_wdata = wdata << 8*off.
- req_wmask = {sb:8'h01, sh:8'h03, sw:8'h0F, sd:8'hFF} << off.
- Load value = resp_rdata >> 8*off.
  - lbu and lhu zero-extend.
  - lh and lw sign-extend (lw sign-extends per RV64).
  - ld uses the full 64 bits.

Bus error: rdata=0 and err_bus=1; store completion also waits for the response.

Latency:
- Accept at T. req_valid at T+1.
- With req_ready at T+1 and resp_valid at T+2, out_valid is at T+3.
- Error and no-op paths: out_valid at T+1.

Boundaries:
- rst mid-operation: return to IDLE, drop req_valid and out_valid immediately, discard latched op. A response arriving after reset is ignored.
- Back-to-back ops: a new op is accepted the cycle after DONE handshake; in_ready is combinational on state only.
- out_ready held low: DONE holds indefinitely with outputs unchanged.
- Address wrap: no carry; aligned address is a pure truncation.

Decomposition:
- Shared package lsu_pkg holds:
  - mem_ctrl code localparams (MEMC_LD … MEMC_SB)
  - FSM state encoding (2-bit)
  - size decode helper (byte/half/word/double)
- One combinational sub-module, lsu_align, generates the store lane shift and mask and the load extract/extend from (mem_ctrl, off, data). The FSM stays in lsu_unit.

Test Plan:
- lw at addr 0x8000_0004:
  - Required response: req_addr=0x8000_0000, req_wmask=0, req_wen=0.
  - Stimulus: resp_rdata=0xF000_0001_2345_6789 → rdata=0xFFFF_FFFF_F000_0001.
  - Latency: with zero-wait bus, out_valid 3 cycles after accept.
- sb at addr 0x8000_0003, wdata=0xAB:
  - Required response: req_wdata byte3=0xAB, req_wmask=8'h08, req_wen=1.
  - Timing: completes after resp_valid.
- lh at addr 0x8000_0001 → no req_valid ever; out_valid at T+1 with err_misalign=1, rdata=0. Repeat with mem_ctrl=0110 → err_illegal=1.
- Bus backpressure on ld 0x10:
  - Stimulus: req_ready low 4 cycles, then resp_err=1.
  - Required response: request fields stable while waiting; out_valid with err_bus=1, rdata=0.
  - Then hold out_ready low 3 cycles: outputs stable and in_ready=0.
- Reset mid-operation: rst asserted while in WAIT → next cycle req_valid=0, out_valid=0, in_ready=1. A resp_valid pulse arriving afterwards is ignored; a new lbu then completes correctly.
- Back-to-back stream sd, ld, lhu to the same doubleword:
  - ld returns the value written by sd.
  - lhu at off=6 returns the zero-extended upper halfword.
  - No dropped or duplicated requests.
